apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Upstream APB requester for the timer subsystem. It accepts single-beat register commands on a valid/ready port, runs each one as an APB SETUP/ACCESS transfer on the `tim_*` bus, and returns read data and error status on a valid/ready response port. A per-transfer watchdog aborts any ACCESS phase that `tim_pready` does not complete within `TIMEOUT` cycles.

## Interface
- `TIMEOUT`, default 16: maximum number of ACCESS cycles per transfer. Must be ≥1.
- `sys_clk`  in  1  the single clock; all logic is rising-edge.
- `sys_rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high at a clock edge.
- `cmd_addr`  in  12  register byte address.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_wdata`  in  32  write data.
- `cmd_strb`  in  4  write byte strobes.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed on `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  32  read data. Always 0 for writes and timeouts.
- `rsp_err`  out  1  the slave returned `pslverr`, or the transfer timed out.
- `rsp_timeout`  out  1  the transfer was aborted by the watchdog.
- `tim_paddr`  out  12  APB address.
- `tim_psel`  out  1  APB select.
- `tim_penable`  out  1  APB enable.
- `tim_pwrite`  out  1  APB direction.
- `tim_pwdata`  out  32  APB write data.
- `tim_pstrb`  out  4  APB strobes.
- `tim_prdata`  in  32  APB read data.
- `tim_pready`  in  1  APB ready.
- `tim_pslverr`  in  1  APB slave error.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. Reset enters IDLE.
- **IDLE**
  - `cmd_ready`=1. It is 0 in every other state.
  - On a handshake, register `cmd_addr`, `cmd_write`, `cmd_wdata` and `cmd_strb`, then go to SETUP.
- **SETUP** (exactly one cycle)
  - `tim_psel`=1, `tim_penable`=0, then go to ACCESS.
  - Clear the watchdog counter.
- **ACCESS**
  - `tim_psel`=1, `tim_penable`=1.
  - If `tim_pready`=1:
    - Capture `tim_prdata` into `rsp_rdata` for reads; use 0 for writes.
    - Set `rsp_err`=`tim_pslverr` and `rsp_timeout`=0.
    - Go to RESP.
  - Else, if the counter equals `TIMEOUT`-1:
    - Abort with `rsp_rdata`=0, `rsp_err`=1, `rsp_timeout`=1.
    - Go to RESP.
  - Else, increment the counter.
  - If `tim_pready` arrives in the final permitted cycle, it wins: the transfer completes normally with no timeout.
- **RESP**
  - `rsp_valid`=1, and the response fields are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
  - `tim_psel` and `tim_penable` are 0.
- **APB address/control/data signals**
  - `tim_paddr`, `tim_pwrite`, `tim_pwdata` and `tim_pstrb` hold the registered command values from SETUP through the end of ACCESS.
  - `tim_pstrb` is forced to 0 for reads.
  - In IDLE and RESP these signals hold their last value; they carry no meaning while `tim_psel`=0.
- **Outputs in flight:** `tim_pslverr` and `tim_prdata` are ignored outside ACCESS with `tim_pready`=1.
- **Watchdog counter width:** `$clog2(TIMEOUT+1)` bits. It never wraps, because ACCESS exits when the counter reaches `TIMEOUT`-1.
- **Reset mid-transfer:** any transfer in progress is abandoned and no response is produced. The timer slave's registers are reset by the same reset.

## Timing
- **Reset values:**
  - `cmd_ready`=1 (IDLE).
  - `rsp_valid`, `rsp_err`, `rsp_timeout`, `tim_psel`, `tim_penable`, `tim_pwrite`=0.
  - `rsp_rdata`, `tim_paddr`, `tim_pwdata`, `tim_pstrb`=0.
- **Latency:**
  - Command handshake at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2.
  - With `tim_pready` high in the first ACCESS cycle, `rsp_valid` rises in cycle N+3.
- **Zero-wait slave:** `tim_pready` tied high gives 2 APB cycles per transfer. With `rsp_ready` held high, commands are accepted every 4 cycles.
- **Each wait state** adds one cycle.
- **Timeout:** ACCESS lasts at most `TIMEOUT` cycles. With `TIMEOUT`=16 and `tim_pready`=0, `rsp_valid` rises 18 cycles after the command handshake.
- **Outputs:** all outputs are registered or decoded from registered state. There is no combinational path from `cmd_valid` or `rsp_ready` to any output.

## Test plan
- **Write, zero-wait:** write addr 0x000, data 0x0000_0003, strb 0xF.
  - Expect `psel`/`penable` waveform 10 then 11.
  - Expect `pstrb`=0xF.
  - Expect `rsp_valid` 3 cycles after the handshake with `rsp_err`=0 and `rsp_rdata`=0.
- **Read, 2 wait states:** read 0x004 with the slave returning 0xDEAD_BEEF.
  - Expect `pstrb`=0 and ACCESS lasting 3 cycles.
  - Expect `rsp_rdata`=0xDEAD_BEEF and `rsp_err`=0.
- **Slave error:** the slave asserts `pslverr` with `pready` on a write to 0xFFC.
  - Expect `rsp_err`=1 and `rsp_timeout`=0.
- **Timeout:** `pready` held 0 with `TIMEOUT`=16.
  - Expect exactly 16 ACCESS cycles, then `psel`=0.
  - Expect `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - Separately: `pready` rising in the 16th ACCESS cycle → normal completion.
- **Response back-pressure:** `rsp_ready` held 0 for 5 cycles.
  - Expect `rsp_*` stable, `cmd_ready`=0, and no APB activity.
  - After release: the next command is accepted one cycle later.
- **Reset mid-ACCESS:** assert `sys_rst` for 1 cycle during a wait state.
  - The next cycle shows all reset values and no `rsp_valid`.
  - A following read completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// Single-beat command to APB requester for the timer subsystem, with a
// per-transfer ACCESS watchdog and a valid/ready response port.
`timescale 1ns/1ps
module apb_cmd_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [11:0] tim_paddr,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [11:0]       paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready is tested first so a completion in the last permitted cycle beats the watchdog
        if (tim_pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : tim_prdata;
          rsp_err_d     = tim_pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: expected responses queued at command
// issue, popped and compared when the response appears.
`timescale 1ns/1ps
module tb_apb_cmd_master;

  localparam int unsigned TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [11:0] tim_paddr;
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;

  always #5 sys_clk = ~sys_clk;

  apb_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .tim_paddr(tim_paddr), .tim_psel(tim_psel), .tim_penable(tim_penable),
    .tim_pwrite(tim_pwrite), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   rsp_seen = 0;

  always @(posedge sys_clk) begin
    if (!sys_rst && rsp_valid && rsp_ready) rsp_seen++;
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err, input logic to);
    rsp_t e;
    e.rdata = rdata; e.err = err; e.to = to;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Issues one command and plays the slave: pready asserted in ACCESS cycle waits+1.
  task automatic run_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic [31:0] prd,
                         input logic serr, output int lat, output int acc, output time hs_t,
                         output logic setup_ok, output logic [3:0] pstrb_seen, output rsp_t got);
    int cyc;
    cyc = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    while (!cmd_ready && cyc < 50) begin
      @(negedge sys_clk);
      cyc++;
    end
    hs_t = $time;
    @(negedge sys_clk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 12'($urandom);
    cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    lat = 1;
    setup_ok = tim_psel && !tim_penable && (tim_paddr == addr) && (tim_pwrite == wr) &&
               (!wr || tim_pwdata == wdata);
    pstrb_seen = tim_pstrb;
    acc = 0;
    @(negedge sys_clk);
    lat = 2;
    while (tim_psel && tim_penable && acc < 40) begin
      acc++;
      tim_pready  = (acc == waits + 1);
      tim_prdata  = tim_pready ? prd : $urandom;
      tim_pslverr = tim_pready ? serr : 1'($urandom);
      @(negedge sys_clk);
      lat++;
      tim_pready = 1'b0;
    end
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge sys_clk);
      lat++;
      cyc++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait rsp_valid=%b expected 1", rsp_valid);
    end
    got = {rsp_rdata, rsp_err, rsp_timeout};
  endtask

  int         lat, acc;
  time        hs_t, hs_prev, t0;
  logic       setup_ok;
  logic [3:0] pstrb_seen;
  rsp_t       got, e;

  task automatic test_reset();
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b1; tim_prdata = '0; tim_pready = 1'b0; tim_pslverr = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, tim_psel, tim_penable, tim_pwrite,
         rsp_rdata, tim_paddr, tim_pwdata, tim_pstrb} !== {1'b1, 86'b0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b val=%b err=%b to=%b sel=%b en=%b wr=%b rd=%h a=%h wd=%h s=%h",
               cmd_ready, rsp_valid, rsp_err, rsp_timeout, tim_psel, tim_penable, tim_pwrite,
               rsp_rdata, tim_paddr, tim_pwdata, tim_pstrb);
    end
  endtask

  task automatic test_write_zero_wait();
    push_exp(32'h0, 1'b0, 1'b0);
    run_cmd(1'b1, 12'h000, 32'h0000_0003, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++; if (!setup_ok) begin errors++; $display("FAIL wr_setup got 0 expected 1"); end
    checks++; if (pstrb_seen !== 4'hF) begin errors++; $display("FAIL wr_pstrb got %h expected f", pstrb_seen); end
    checks++; if (acc !== 1) begin errors++; $display("FAIL wr_access got %0d expected 1", acc); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d expected 3", lat); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL wr_rsp got %h expected %h", got, e); end
    @(negedge sys_clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_consume got val=%b rdy=%b expected 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait2();
    push_exp(32'hDEAD_BEEF, 1'b0, 1'b0);
    run_cmd(1'b0, 12'h004, 32'h1111_1111, 4'hF, 2, 32'hDEAD_BEEF, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++; if (!setup_ok) begin errors++; $display("FAIL rd_setup got 0 expected 1"); end
    checks++; if (pstrb_seen !== 4'h0) begin errors++; $display("FAIL rd_pstrb got %h expected 0", pstrb_seen); end
    checks++; if (acc !== 3) begin errors++; $display("FAIL rd_access got %0d expected 3", acc); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rd_latency got %0d expected 5", lat); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL rd_rsp got %h expected %h", got, e); end
    @(negedge sys_clk);
  endtask

  task automatic test_slave_error();
    push_exp(32'h0, 1'b1, 1'b0);
    run_cmd(1'b1, 12'hFFC, 32'h0000_00A5, 4'h3, 1, 32'h5555_AAAA, 1'b1, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++; if (pstrb_seen !== 4'h3) begin errors++; $display("FAIL err_pstrb got %h expected 3", pstrb_seen); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL err_rsp got %h expected %h", got, e); end
    @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    push_exp(32'h0, 1'b1, 1'b1);
    run_cmd(1'b0, 12'h008, 32'h0, 4'h0, 1000, 32'h0, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++; if (acc !== 16) begin errors++; $display("FAIL to_access got %0d expected 16", acc); end
    checks++; if (lat !== 18) begin errors++; $display("FAIL to_latency got %0d expected 18", lat); end
    checks++; if (tim_psel !== 1'b0) begin errors++; $display("FAIL to_psel got %b expected 0", tim_psel); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL to_rsp got %h expected %h", got, e); end
    @(negedge sys_clk);
    push_exp(32'h7654_3210, 1'b0, 1'b0);
    run_cmd(1'b0, 12'h00C, 32'h0, 4'h0, 15, 32'h7654_3210, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++; if (acc !== 16) begin errors++; $display("FAIL last_access got %0d expected 16", acc); end
    checks++; if (lat !== 18) begin errors++; $display("FAIL last_latency got %0d expected 18", lat); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL last_rsp got %h expected %h", got, e); end
    @(negedge sys_clk);
  endtask

  task automatic test_back_to_back();
    push_exp(32'h0, 1'b0, 1'b0);
    run_cmd(1'b1, 12'h040, 32'hAAAA_0001, 4'h1, 0, 32'h0, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    hs_prev = hs_t;
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL b2b_rsp0 got %h expected %h", got, e); end
    push_exp(32'h0, 1'b0, 1'b0);
    run_cmd(1'b1, 12'h044, 32'hBBBB_0002, 4'h2, 0, 32'h0, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++;
    if (hs_t - hs_prev !== 40) begin
      errors++; $display("FAIL b2b_interval got %0t expected 40", hs_t - hs_prev);
    end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL b2b_rsp1 got %h expected %h", got, e); end
    @(negedge sys_clk);
  endtask

  task automatic test_backpressure();
    logic [34:0] snap;
    logic        hold_ok;
    rsp_ready = 1'b0;
    push_exp(32'h1234_5678, 1'b0, 1'b0);
    run_cmd(1'b0, 12'h010, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    snap = {rsp_valid, rsp_rdata, rsp_err, rsp_timeout};
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_wdata = '0; cmd_strb = '0;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      tim_prdata = $urandom;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== snap || cmd_ready !== 1'b0 ||
          tim_psel !== 1'b0 || tim_penable !== 1'b0) hold_ok = 1'b0;
    end
    checks++; if (!hold_ok) begin errors++; $display("FAIL bp_hold got unstable expected stable"); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL bp_rsp got %h expected %h", got, e); end
    rsp_ready = 1'b1;
    t0 = $time;
    push_exp(32'h0BAD_F00D, 1'b0, 1'b0);
    run_cmd(1'b0, 12'h020, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++;
    if (hs_t - t0 !== 10) begin errors++; $display("FAIL bp_accept got %0t expected 10", hs_t - t0); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL bp_next_rsp got %h expected %h", got, e); end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h0AC; cmd_wdata = 32'hA5A5_0F0F;
    cmd_strb = 4'h6; tim_pready = 1'b0;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (!(tim_psel && tim_penable && tim_paddr == 12'h0AC && tim_pstrb == 4'h6)) begin
      errors++; $display("FAIL rst_pre got sel=%b en=%b a=%h expected 1 1 0ac", tim_psel, tim_penable, tim_paddr);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, tim_psel, tim_penable, tim_pwrite,
         rsp_rdata, tim_paddr, tim_pwdata, tim_pstrb} !== {1'b1, 86'b0}) begin
      errors++;
      $display("FAIL rst_mid_values got rdy=%b val=%b sel=%b en=%b wr=%b rd=%h a=%h wd=%h s=%h",
               cmd_ready, rsp_valid, tim_psel, tim_penable, tim_pwrite, rsp_rdata, tim_paddr,
               tim_pwdata, tim_pstrb);
    end
    push_exp(32'hCAFE_0001, 1'b0, 1'b0);
    run_cmd(1'b0, 12'h0B0, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b0, lat, acc, hs_t, setup_ok, pstrb_seen, got);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rst_next_latency got %0d expected 4", lat); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL rst_next_rsp got %h expected %h", got, e); end
    @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait2();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge sys_clk);
    checks++;
    if (rsp_seen !== n_push) begin
      errors++; $display("FAIL rsp_count got %0d expected %0d", rsp_seen, n_push);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
